// File: rtl/fetch_stage.sv
// fetch_stage: RV32IMC instruction fetch, directly upstream of decode.
// Issues word-aligned reads on the instruction bus and realigns 16/32-bit
// instructions with a one-halfword spare buffer and a one-word parking buffer.
// Ports:
//   clk, rst (sync, active low)
//   imem_valid/imem_addr  -> word request, held until imem_ready
//   imem_ready/imem_rdata/imem_error <- response strobe, data, access fault
//   stall        : decode/execute stall, packet outputs hold
//   redirect/redirect_pc : decode redirect, highest priority
//   pc_out/instr_out/valid_out/exception_out/ecause_out/etval_out : packet
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_valid,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        imem_error,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        valid_out,
  output logic        exception_out,
  output logic [3:0]  ecause_out,
  output logic [31:0] etval_out
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] r_faddr, r_ipc, r_imem_addr, r_wbuf;
  logic [15:0] r_spare;
  logic        r_spare_v, r_wbuf_v, r_wbuf_err, r_pend, r_drop, r_halt;
  logic [31:0] r_pc_out, r_instr_out, r_etval_out;
  logic        r_valid_out, r_exc_out;
  logic [3:0]  r_ecause_out;

  function automatic logic is_c(input logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction

  logic        w_resp, w_live, w_have, w_sp_c, w_issue, w_werr;
  logic [31:0] w_word;
  logic [15:0] w_lo, w_hi;
  logic        w_emit, w_exc, w_use, w_spare_v_nxt;
  logic [31:0] w_instr, w_ipc_nxt;
  logic [15:0] w_spare_nxt;

  assign w_resp = r_pend & imem_ready;
  assign w_live = w_resp & ~r_drop;
  // Parked word has priority; a live response can only arrive when wbuf is empty.
  assign w_have = r_wbuf_v | w_live;
  assign w_word = r_wbuf_v ? r_wbuf : imem_rdata;
  assign w_werr = r_wbuf_v ? r_wbuf_err : imem_error;
  assign w_lo   = w_word[15:0];
  assign w_hi   = w_word[31:16];
  // A compressed spare is a complete instruction needing no memory word.
  assign w_sp_c = r_spare_v & is_c(r_spare);
  assign w_issue = ~r_pend & ~r_halt & ~r_wbuf_v & ~w_sp_c;

  always_comb begin
    w_emit        = 1'b0;
    w_exc         = 1'b0;
    w_use         = 1'b0;
    w_instr       = 32'h0;
    w_ipc_nxt     = r_ipc;
    w_spare_nxt   = r_spare;
    w_spare_v_nxt = r_spare_v;
    if (!r_halt) begin
      if (w_sp_c) begin
        w_emit        = 1'b1;
        w_instr       = {16'h0, r_spare};
        w_ipc_nxt     = r_ipc + 32'd2;
        w_spare_v_nxt = 1'b0;
      end else if (w_have) begin
        w_use = 1'b1;
        if (w_werr) begin
          w_exc         = 1'b1;
          w_spare_v_nxt = 1'b0;
        end else if (r_spare_v) begin
          // spare is the low half of a 32-bit instruction spanning words
          w_emit        = 1'b1;
          w_instr       = {w_lo, r_spare};
          w_ipc_nxt     = r_ipc + 32'd4;
          w_spare_nxt   = w_hi;
          w_spare_v_nxt = 1'b1;
        end else if (!r_ipc[1]) begin
          w_emit = 1'b1;
          if (is_c(w_lo)) begin
            w_instr       = {16'h0, w_lo};
            w_ipc_nxt     = r_ipc + 32'd2;
            w_spare_nxt   = w_hi;
            w_spare_v_nxt = 1'b1;
          end else begin
            w_instr   = w_word;
            w_ipc_nxt = r_ipc + 32'd4;
          end
        end else if (is_c(w_hi)) begin
          w_emit    = 1'b1;
          w_instr   = {16'h0, w_hi};
          w_ipc_nxt = r_ipc + 32'd2;
        end else begin
          // upper half starts a 32-bit instruction: wait for the next word
          w_spare_nxt   = w_hi;
          w_spare_v_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_faddr      <= RESET_PC & ~32'd3;
      r_ipc        <= RESET_PC;
      r_imem_addr  <= RESET_PC & ~32'd3;
      r_wbuf       <= 32'h0;
      r_wbuf_v     <= 1'b0;
      r_wbuf_err   <= 1'b0;
      r_spare      <= 16'h0;
      r_spare_v    <= 1'b0;
      r_pend       <= 1'b0;
      r_drop       <= 1'b0;
      r_halt       <= 1'b0;
      r_pc_out     <= RESET_PC;
      r_instr_out  <= NOP;
      r_valid_out  <= 1'b0;
      r_exc_out    <= 1'b0;
      r_ecause_out <= 4'd0;
      r_etval_out  <= 32'h0;
    end else if (redirect) begin
      r_ipc     <= redirect_pc;
      r_faddr   <= redirect_pc & ~32'd3;
      r_spare_v <= 1'b0;
      r_wbuf_v  <= 1'b0;
      r_halt    <= redirect_pc[0];
      // An in-flight request stays on the bus until it completes; its data is
      // discarded. A response landing this very cycle is simply ignored.
      if (w_resp) r_pend <= 1'b0;
      r_drop    <= r_pend & ~imem_ready;
      r_valid_out  <= redirect_pc[0];
      r_exc_out    <= redirect_pc[0];
      r_ecause_out <= 4'd0;
      if (redirect_pc[0]) begin
        r_pc_out    <= redirect_pc;
        r_instr_out <= 32'h0;
        r_etval_out <= redirect_pc;
      end
    end else begin
      if (w_resp) begin
        r_pend <= 1'b0;
        if (r_drop) r_drop  <= 1'b0;
        else        r_faddr <= r_faddr + 32'd4;
      end else if (w_issue) begin
        r_pend      <= 1'b1;
        r_imem_addr <= r_faddr;
      end
      // Park a live word that is not consumed straight off the bus.
      if (w_live && (stall || !w_use)) begin
        r_wbuf     <= imem_rdata;
        r_wbuf_err <= imem_error;
        r_wbuf_v   <= 1'b1;
      end
      if (!stall) begin
        r_ipc       <= w_ipc_nxt;
        r_spare     <= w_spare_nxt;
        r_spare_v   <= w_spare_v_nxt;
        if (w_use && r_wbuf_v) r_wbuf_v <= 1'b0;
        r_valid_out <= w_emit | w_exc;
        r_exc_out   <= w_exc;
        if (w_emit || w_exc) begin
          r_pc_out     <= r_ipc;
          r_instr_out  <= w_instr;
          r_ecause_out <= w_exc ? 4'd1 : 4'd0;
          r_etval_out  <= w_exc ? r_ipc : 32'h0;
        end
        if (w_exc) r_halt <= 1'b1;
      end
    end
  end

  assign imem_valid    = r_pend;
  assign imem_addr     = r_imem_addr;
  assign pc_out        = r_pc_out;
  assign instr_out     = r_instr_out;
  assign valid_out     = r_valid_out;
  assign exception_out = r_exc_out;
  assign ecause_out    = r_ecause_out;
  assign etval_out     = r_etval_out;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_valid, imem_ready, imem_error;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out, instr_out, etval_out;
  logic        valid_out, exception_out;
  logic [3:0]  ecause_out;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .imem_error(imem_error),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc_out(pc_out), .instr_out(instr_out), .valid_out(valid_out),
    .exception_out(exception_out), .ecause_out(ecause_out), .etval_out(etval_out)
  );

  // zero-wait memory model, gated by mem_en
  logic [31:0] mem [0:255];
  logic        mem_en, err_en;
  logic [31:0] err_addr;
  assign imem_ready = imem_valid & mem_en;
  assign imem_rdata = mem[imem_addr[9:2]];
  assign imem_error = imem_valid & err_en & (imem_addr == err_addr);

  typedef struct {
    logic [31:0] pc, instr, tv;
    logic        exc;
    logic [3:0]  ec;
    int          nreq;
  } pkt_t;
  pkt_t        pq[$];
  logic [31:0] rq[$];

  // consumed packets and accepted bus requests
  always @(negedge clk) begin
    if (rst) begin
      if (valid_out && !stall) begin
        pkt_t p;
        p.pc = pc_out; p.instr = instr_out; p.tv = etval_out;
        p.exc = exception_out; p.ec = ecause_out; p.nreq = rq.size();
        pq.push_back(p);
      end
      if (imem_valid && imem_ready) rq.push_back(imem_addr);
    end
  end

  typedef struct {
    logic [31:0] w0, w1, w2, pc0, pc1, pc2, i0, i1, i2;
    int          nreq1;
  } vec_t;
  vec_t vt[4];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
  endtask

  task automatic do_reset();
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    tick(3);
    rst = 1'b1;
    pq.delete(); rq.delete();
  endtask

  task automatic wait_pkts(input int n, input int maxc, input string nm);
    int c = 0;
    while (pq.size() < n && c < maxc) begin tick(1); c++; end
    checks++;
    if (pq.size() < n) begin
      errors++;
      $display("FAIL %s timeout got %0d packets want %0d", nm, pq.size(), n);
    end
  endtask

  initial begin
    int n;
    vt[0] = '{32'h00500093, 32'h00A00113, 32'h00000013, 32'h0, 32'h4, 32'h8,
              32'h00500093, 32'h00A00113, 32'h00000013, 2};
    vt[1] = '{32'h05050585, 32'h00500093, 32'h00000013, 32'h0, 32'h2, 32'h4,
              32'h00000585, 32'h00000505, 32'h00500093, 1};
    vt[2] = '{32'h00934505, 32'h00000050, 32'h00000013, 32'h0, 32'h2, 32'h6,
              32'h00004505, 32'h00500093, 32'h00000000, 2};
    vt[3] = '{32'h00930001, 32'h00010050, 32'h00000013, 32'h0, 32'h2, 32'h6,
              32'h00000001, 32'h00500093, 32'h00000001, 2};
    mem_en = 1'b1; err_en = 1'b0; err_addr = 32'h0;
    clear_mem();

    // reset state, sampled while rst is still low
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    tick(3);
    chk("rst_imem_valid", {31'h0, imem_valid}, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_instr_out", instr_out, 32'h00000013);
    chk("rst_valid_out", {31'h0, valid_out}, 32'h0);
    chk("rst_exception", {31'h0, exception_out}, 32'h0);
    chk("rst_ecause", {28'h0, ecause_out}, 32'h0);
    chk("rst_etval", etval_out, 32'h0);
    rst = 1'b1;
    tick(1);
    chk("first_req_valid", {31'h0, imem_valid}, 32'h1);

    // table-driven realignment vectors, zero-wait memory
    for (int v = 0; v < 4; v++) begin
      clear_mem();
      mem[0] = vt[v].w0; mem[1] = vt[v].w1; mem[2] = vt[v].w2;
      do_reset();
      wait_pkts(3, 40, $sformatf("v%0d_pkts", v));
      chk($sformatf("v%0d_pc0", v), pq[0].pc, vt[v].pc0);
      chk($sformatf("v%0d_pc1", v), pq[1].pc, vt[v].pc1);
      chk($sformatf("v%0d_pc2", v), pq[2].pc, vt[v].pc2);
      chk($sformatf("v%0d_i0", v), pq[0].instr, vt[v].i0);
      chk($sformatf("v%0d_i1", v), pq[1].instr, vt[v].i1);
      chk($sformatf("v%0d_i2", v), pq[2].instr, vt[v].i2);
      for (int k = 0; k < 3; k++)
        chk($sformatf("v%0d_exc%0d", v, k), {31'h0, pq[k].exc}, 32'h0);
      chk($sformatf("v%0d_ecause0", v), {28'h0, pq[0].ec}, 32'h0);
      chk($sformatf("v%0d_nreq1", v), pq[1].nreq, vt[v].nreq1);
    end

    // stall held 3 cycles while the second word arrives
    clear_mem();
    mem[0] = 32'h00500093; mem[1] = 32'h00A00113;
    do_reset();
    n = 0;
    while (!valid_out && n < 20) begin tick(1); n++; end
    chk("stall_first_valid", {31'h0, valid_out}, 32'h1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall_hold_valid%0d", i), {31'h0, valid_out}, 32'h1);
      chk($sformatf("stall_hold_pc%0d", i), pc_out, 32'h0);
      tick(1);
    end
    stall = 1'b0;
    chk("stall_nreq", rq.size(), 32'd2);
    wait_pkts(2, 20, "stall_pkts");
    chk("stall_pc0", pq[0].pc, 32'h0);
    chk("stall_pc1", pq[1].pc, 32'h4);
    chk("stall_i1", pq[1].instr, 32'h00A00113);

    // redirect to 0x102 while the request to 0 is still pending
    clear_mem();
    mem[0] = 32'h00500093; mem[64] = 32'h45050093;
    mem_en = 1'b0;
    do_reset();
    tick(2);
    redirect = 1'b1; redirect_pc = 32'h102;
    tick(1);
    redirect = 1'b0; mem_en = 1'b1;
    pq.delete(); rq.delete();
    wait_pkts(1, 20, "redir_pkts");
    chk("redir_pc", pq[0].pc, 32'h102);
    chk("redir_instr", pq[0].instr, 32'h00004505);
    chk("redir_addr", (rq.size() >= 2) ? rq[1] : 32'hxxxxxxxx, 32'h100);

    // misaligned redirect target
    redirect = 1'b1; redirect_pc = 32'h101;
    tick(1);
    redirect = 1'b0;
    chk("mis_valid", {31'h0, valid_out}, 32'h1);
    chk("mis_exc", {31'h0, exception_out}, 32'h1);
    chk("mis_ecause", {28'h0, ecause_out}, 32'h0);
    chk("mis_etval", etval_out, 32'h101);

    // access fault at 0x200, then halt until redirect
    err_en = 1'b1; err_addr = 32'h200;
    redirect = 1'b1; redirect_pc = 32'h200;
    tick(1);
    redirect = 1'b0;
    pq.delete();
    wait_pkts(1, 20, "err_pkts");
    chk("err_exc", {31'h0, pq[0].exc}, 32'h1);
    chk("err_ecause", {28'h0, pq[0].ec}, 32'h1);
    chk("err_etval", pq[0].tv, 32'h200);
    chk("err_instr", pq[0].instr, 32'h0);
    n = rq.size();
    tick(10);
    chk("halt_nreq", rq.size(), n);
    chk("halt_imem_valid", {31'h0, imem_valid}, 32'h0);
    chk("halt_valid_out", {31'h0, valid_out}, 32'h0);
    err_en = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0;
    tick(1);
    redirect = 1'b0;
    pq.delete();
    wait_pkts(1, 20, "recover_pkts");
    chk("recover_pc", pq[0].pc, 32'h0);
    chk("recover_instr", pq[0].instr, 32'h00500093);
    chk("recover_exc", {31'h0, pq[0].exc}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the in-order RV32IMC pipeline, directly upstream of decode. It issues word-aligned reads on the instruction memory bus and realigns 16-bit and 32-bit instructions across word boundaries with a one-halfword spare buffer. It delivers one registered instruction packet per accepted cycle (pc, instr, exception, ecause, etval) and handles redirects from decode (jump, mret, exception), decode/execute stalls and instruction access faults.

## Interface
- RESET_PC, 32'h00000000, first fetch address after reset (halfword aligned)
- rst  in  1  synchronous reset, active low
- clk  in  1  clock
- imem_valid  out  1  request valid; registered, held until imem_ready
- imem_addr  out  32  request address; word aligned, stable while imem_valid=1
- imem_ready  in  1  response strobe; imem_rdata/imem_error valid this cycle
- imem_rdata  in  32  read word
- imem_error  in  1  access fault for this response
- stall  in  1  decode or execute stall; hold outputs
- redirect  in  1  decode redirect request
- redirect_pc  in  32  redirect target
- pc_out  out  32  instruction address
- instr_out  out  32  instruction; compressed instructions zero-extended in [31:16]
- valid_out  out  1  packet valid
- exception_out  out  1  fetch exception
- ecause_out  out  4  0 = misaligned target, 1 = instruction access fault
- etval_out  out  32  faulting address

## Operation
- State: faddr (next word address), ipc (next instruction pc), spare[15:0] + spare_v, wbuf[31:0] + wbuf_v, pend (request outstanding), drop (discard next response), halt.
- Request issue: assert imem_valid next cycle when pend=0, halt=0, wbuf_v=0, and not (spare_v with spare[1:0]!=11). imem_addr=faddr. After ready: faddr+=4, pend=0.
- Response with stall=1 or drop=0 and packet slot busy: word stored in wbuf. With drop=1: discarded, drop cleared.
- Alignment on the available word W (direct from bus, else wbuf), lo=W[15:0], hi=W[31:16]:
  - spare_v, spare compressed: emit spare at ipc, ipc+=2, spare_v=0, W untouched, no memory access needed.
  - spare_v, spare is low half of 32-bit: emit {lo,spare}, ipc+=4, spare=hi, spare_v=1.
  - no spare, ipc[1]=0: lo compressed -> emit lo, ipc+=2, spare=hi, spare_v=1; else emit W, ipc+=4.
  - no spare, ipc[1]=1: hi compressed -> emit hi, ipc+=2; else spare=hi, spare_v=1, no emit.
- Compressed test: halfword[1:0]!=2'b11.
- Emit: pc_out=ipc, instr_out, valid_out=1, exception_out=0. No emit while stall=1: outputs hold; nothing consumed.
- imem_error on a non-dropped response: emit exception_out=1, ecause=1, etval=ipc, valid_out=1, instr_out=0; set halt. Spare contents discarded.
- redirect=1 (priority over stall and all else): ipc=redirect_pc, faddr=redirect_pc&~3, spare_v=0, wbuf_v=0, halt=0, valid_out=0 next cycle; drop=pend (an in-flight request completes, its data ignored). If redirect_pc[0]=1: next cycle emit exception_out=1, ecause=0, etval=redirect_pc, set halt.
- halt: no requests, valid_out=0 after the exception packet is consumed, until redirect.

## Timing
- Reset values: imem_valid=0, imem_addr=RESET_PC&~3, pc_out=RESET_PC, instr_out=32'h00000013, valid_out=0, exception_out=0, ecause_out=0, etval_out=0. Internal: ipc=RESET_PC, all valid bits, pend, drop and halt 0.
- Reset mid-request abandons it. The bus must tolerate the dropped transaction.
- First imem_valid=1 in the first cycle after rst goes high.
- imem_ready allowed in the same cycle as imem_valid (zero wait). Packet is visible the cycle after imem_ready (1-cycle latency).
- Max one word per 2 cycles. A compressed spare emits in the cycle after the word that produced it.
- stall and redirect in the same cycle: redirect wins.

## Test plan
- Reset, RESET_PC=0, zero-wait memory returning 32'h00500093 at 0, 32'h00A00113 at 4 -> packets pc 0 then pc 4 with those instrs, ecause 0.
- Word 0 = 32'h0505_0585 (two c.addi) -> pc 0 instr 32'h00000585, then pc 2 instr 32'h00000505 without a memory request in between.
- Word 0 = 32'h0093_4505, word 4 = 32'h0000_0050 -> pc 0 instr 32'h00004505, then pc 2 instr 32'h00500093 (spanning).
- stall held 3 cycles while a response arrives -> outputs frozen, word in wbuf, correct next packet after release, no duplicate.
- redirect to 32'h102 while a request is pending -> pending data dropped, next imem_addr 32'h100, first packet pc 32'h102 from hi half. redirect to 32'h101 -> exception_out=1, ecause 0, etval 32'h101.
- imem_error on fetch of 32'h200 -> exception_out=1, ecause 1, etval 32'h200, no further imem_valid until redirect.
